// File: rtl/sram_spi_controller.sv
// SPI SRAM job controller: serialises an 8-bit instruction and 24-bit address, then streams
// byte_length bytes in mode 0 at clk/2, bit-serially to/from the requester.
module sram_spi_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  inst,
    input  logic [23:0] address,
    input  logic [23:0] byte_length,
    input  logic        write_in,
    output logic        mem_out,
    output logic        io_valid,
    output logic        rw_done,
    output logic        sram_cs_n,
    output logic        sram_sck,
    output logic        sram_mosi,
    input  logic        sram_miso
);

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StDone} state_e;

    state_e      state;
    logic        phase;     // 0 = sck low phase, 1 = sck high phase; first/second cycle in StDone
    logic        is_read;
    logic [30:0] shreg;     // header bits still to send after the one on sram_mosi
    logic [23:0] len;
    logic [26:0] bit_cnt;   // bits remaining in the current phase, minus one

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            phase     <= 1'b0;
            is_read   <= 1'b0;
            shreg     <= '0;
            len       <= '0;
            bit_cnt   <= '0;
            sram_cs_n <= 1'b1;
            sram_sck  <= 1'b0;
            sram_mosi <= 1'b0;
            mem_out   <= 1'b0;
            io_valid  <= 1'b0;
            rw_done   <= 1'b0;
        end else begin
            io_valid <= 1'b0;
            rw_done  <= 1'b0;
            case (state)
                StIdle: begin
                    if (inst == 8'd3 || inst == 8'd2) begin
                        state     <= StCmd;
                        is_read   <= (inst == 8'd3);
                        shreg     <= {inst[6:0], address};
                        len       <= byte_length;
                        bit_cnt   <= 27'd7;
                        phase     <= 1'b0;
                        sram_cs_n <= 1'b0;
                        sram_sck  <= 1'b0;
                        sram_mosi <= inst[7];
                    end
                end
                StCmd, StAddr, StData: begin
                    if (!phase) begin
                        phase    <= 1'b1;
                        sram_sck <= 1'b1;
                        // Write data is requested one bit ahead of the bit that carries it.
                        if (!is_read && len != 24'd0 &&
                            ((state == StAddr && bit_cnt == 27'd0) ||
                             (state == StData && bit_cnt != 27'd0))) begin
                            io_valid <= 1'b1;
                        end
                    end else begin
                        phase    <= 1'b0;
                        sram_sck <= 1'b0;
                        if (state == StData && is_read) begin
                            mem_out  <= sram_miso;
                            io_valid <= 1'b1;
                        end
                        if (bit_cnt != 27'd0) begin
                            bit_cnt <= bit_cnt - 27'd1;
                            if (state == StData) begin
                                sram_mosi <= is_read ? 1'b0 : write_in;
                            end else begin
                                sram_mosi <= shreg[30];
                                shreg     <= {shreg[29:0], 1'b0};
                            end
                        end else if (state == StCmd) begin
                            state     <= StAddr;
                            bit_cnt   <= 27'd23;
                            sram_mosi <= shreg[30];
                            shreg     <= {shreg[29:0], 1'b0};
                        end else if (state == StAddr && len != 24'd0) begin
                            state     <= StData;
                            bit_cnt   <= {len, 3'b000} - 27'd1;
                            sram_mosi <= is_read ? 1'b0 : write_in;
                        end else begin
                            state     <= StDone;
                            sram_cs_n <= 1'b1;
                            sram_mosi <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (!phase) begin
                        phase   <= 1'b1;
                        rw_done <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_spi_controller.sv
// Scoreboard bench for sram_spi_controller with a behavioural SPI SRAM and serial requester.
module tb_sram_spi_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  inst = 8'd0;
    logic [23:0] address = 24'd0;
    logic [23:0] byte_length = 24'd0;
    logic        write_in = 1'b0;
    logic        sram_miso = 1'b0;
    logic        mem_out, io_valid, rw_done, sram_cs_n, sram_sck, sram_mosi;

    sram_spi_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .inst        (inst),
        .address     (address),
        .byte_length (byte_length),
        .write_in    (write_in),
        .mem_out     (mem_out),
        .io_valid    (io_valid),
        .rw_done     (rw_done),
        .sram_cs_n   (sram_cs_n),
        .sram_sck    (sram_sck),
        .sram_mosi   (sram_mosi),
        .sram_miso   (sram_miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_mosi[$];
    logic       exp_rd[$];
    logic [7:0] rd_data [0:1] = '{8'hA5, 8'h3C};
    logic [7:0] wr_byte = 8'h96;
    logic [7:0] rx_byte = 8'd0;
    int         rx_bits = 0;
    int         spi_bits = 0;
    int         spi_d = 0;
    int         io_cnt = 0;
    int         wr_idx = 0;
    logic       cur_read = 1'b0;
    logic       mosi_rise = 1'b0;

    // SRAM model: captures MOSI on rising sck, presents read data during the high phase.
    always @(posedge sram_sck) begin
        mosi_rise = sram_mosi;
        spi_bits++;
        rx_bits++;
        rx_byte = {rx_byte[6:0], sram_mosi};
        if (rx_bits % 8 == 0 && (rx_bits <= 32 || !cur_read)) begin
            if (exp_mosi.size() == 0) check("mosi_unexpected_byte", 32'd1, 32'd0);
            else check("mosi_byte", rx_byte, exp_mosi.pop_front());
        end
        if (spi_bits > 32) begin
            spi_d = spi_bits - 33;
            if (spi_d < 16) sram_miso = rd_data[spi_d / 8][7 - spi_d % 8];
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (sram_cs_n) begin
                check("sck_idle", sram_sck, 1'b0);
                check("mosi_idle", sram_mosi, 1'b0);
            end else if (sram_sck) begin
                check("mosi_stable", sram_mosi, mosi_rise);
            end
            if (io_valid) begin
                io_cnt++;
                if (cur_read) begin
                    if (exp_rd.size() == 0) check("rd_unexpected_bit", 32'd1, 32'd0);
                    else check("mem_out", mem_out, exp_rd.pop_front());
                end
            end
        end
    end

    // Requester: advance write_in after each consumed bit.
    always @(negedge clk) begin
        if (reset_n && io_valid && !cur_read) begin
            @(posedge clk);
            #1;
            wr_idx++;
            write_in = (wr_idx < 8) ? wr_byte[7 - wr_idx] : 1'b0;
        end
    end

    task automatic do_job(input logic [7:0] i, input logic [23:0] a, input logic [23:0] len,
                          input bit hold, input int exp_wait, input int exp_lat);
        int  w;
        int  lat;
        bit  ok;
        exp_mosi.delete();
        exp_rd.delete();
        rx_bits = 0;
        spi_bits = 0;
        io_cnt = 0;
        sram_miso = 1'b0;
        cur_read = (i == 8'd3);
        exp_mosi.push_back(i);
        exp_mosi.push_back(a[23:16]);
        exp_mosi.push_back(a[15:8]);
        exp_mosi.push_back(a[7:0]);
        if (!cur_read) begin
            for (int k = 0; k < int'(len); k++) exp_mosi.push_back(wr_byte);
            wr_idx = 0;
            write_in = wr_byte[7];
        end else begin
            for (int k = 0; k < int'(len) * 8; k++) exp_rd.push_back(rd_data[k / 8][7 - k % 8]);
        end
        inst = i;
        address = a;
        byte_length = len;
        w = 0;
        ok = 0;
        while (!ok && w < 10) begin
            @(posedge clk);
            #1;
            w++;
            if (!sram_cs_n) ok = 1;
        end
        check("accept_wait", w, exp_wait);
        if (!ok) return;
        if (!hold) begin
            inst = 8'd0;
            address = 24'hFFFFFF;
            byte_length = 24'd5;
        end
        lat = 2;
        while (!rw_done && lat < 5000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("io_pulses", io_cnt, len * 8);
        check("mosi_left", exp_mosi.size(), 0);
        check("rd_left", exp_rd.size(), 0);
        if (cur_read && len != 24'd0) check("mem_out_hold", mem_out, rd_data[len - 1][0]);
    endtask

    task automatic idle_gap();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #7;
        check("rst_cs_n", sram_cs_n, 1'b1);
        check("rst_sck", sram_sck, 1'b0);
        check("rst_mosi", sram_mosi, 1'b0);
        check("rst_mem_out", mem_out, 1'b0);
        check("rst_io_valid", io_valid, 1'b0);
        check("rst_rw_done", rw_done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        do_job(8'd3, 24'h000010, 24'd2, 1'b0, 1, 99);
        idle_gap();
        do_job(8'd2, 24'h00ABCD, 24'd1, 1'b0, 1, 83);
        idle_gap();
        do_job(8'd3, 24'h123456, 24'd0, 1'b0, 1, 67);
        idle_gap();

        inst = 8'd5;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("inst5_ignored", sram_cs_n, 1'b1);
        end
        do_job(8'd3, 24'h000020, 24'd1, 1'b1, 1, 83);
        do_job(8'd3, 24'h000020, 24'd1, 1'b0, 2, 83);
        idle_gap();

        // Abort a READ part-way through the address phase.
        exp_mosi.delete();
        exp_rd.delete();
        rx_bits = 0;
        spi_bits = 0;
        cur_read = 1'b1;
        exp_mosi.push_back(8'h03);
        exp_mosi.push_back(8'h00);
        exp_mosi.push_back(8'h00);
        exp_mosi.push_back(8'h40);
        inst = 8'd3;
        address = 24'h000040;
        byte_length = 24'd2;
        @(posedge clk);
        #1;
        check("abort_job_started", sram_cs_n, 1'b0);
        inst = 8'd0;
        repeat (39) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_cs_n", sram_cs_n, 1'b1);
        check("abort_sck", sram_sck, 1'b0);
        check("abort_mosi", sram_mosi, 1'b0);
        check("abort_io_valid", io_valid, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            check("abort_no_rw_done", rw_done, 1'b0);
            check("abort_stays_idle", sram_cs_n, 1'b1);
        end
        do_job(8'd3, 24'h000100, 24'd1, 1'b0, 1, 83);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
